// File: rtl/piano_key_encoder.sv
// Piano key encoder: synchronises and debounces each push-button, picks the
// lowest held key and presents it to the tone generator as a registered note
// index, a note_on gate and a one-cycle note_change pulse.
//
// state | meaning
// IDLE  | no debounced key held, note_on = 0, note keeps last value
// PLAY  | at least one debounced key held, note = lowest held key
module piano_key_encoder #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int NUM_KEYS        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys,
   output logic [2:0]          note,
   output logic                note_on,
   output logic                note_change
);

   localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] stab;
   logic [23:0]         cnt [NUM_KEYS];

   logic [7:0] pri;
   logic [2:0] win;
   logic       any;

   state_t     state, state_n;
   logic [2:0] note_n;
   logic       chg_n;

   // Two-flop synchroniser on every raw key level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
      end
   end

   // Per-key debounce: stab follows sync only after DEBOUNCE_CYCLES of disagreement
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab <= '0;
         for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2[i] == stab[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               stab[i] <= sync2[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 24'd1;
            end
         end
      end
   end

   // Lowest-index priority over the debounced keys; unused upper inputs read as 0
   always_comb begin
      pri              = '0;
      pri[NUM_KEYS-1:0] = stab;
      any              = |pri;
      win              = '0;
      for (int i = 7; i >= 0; i--) begin
         if (pri[i]) win = 3'(i);
      end
   end

   // Output FSM state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         note        <= '0;
         note_change <= 1'b0;
      end else begin
         state       <= state_n;
         note        <= note_n;
         note_change <= chg_n;
      end
   end

   // Next-state, next-note and change-pulse decode from current debounced keys
   always_comb begin
      state_n = state;
      note_n  = note;
      chg_n   = 1'b0;
      case (state)
         IDLE: begin
            if (any) begin
               state_n = PLAY;
               note_n  = win;
               chg_n   = 1'b1;
            end
         end
         PLAY: begin
            if (!any) begin
               state_n = IDLE;
               chg_n   = 1'b1;
            end else if (win != note) begin
               note_n = win;
               chg_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign note_on = (state == PLAY);

endmodule

// File: tb/tb_piano_key_encoder.sv
// Directed bench for piano_key_encoder with a small debounce window.
// Each stimulus step pushes the expected output event and the cycle it must
// appear on; a negedge monitor pops one entry per note_change pulse.
module tb_piano_key_encoder;

   localparam int DEB = 4;
   localparam int NK  = 8;
   localparam int LAT = DEB + 3;

   typedef struct {
      logic       on;
      logic [2:0] nt;
      int         cyc;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NK-1:0] keys = '0;
   logic [2:0]    note;
   logic          note_on;
   logic          note_change;

   int  errors = 0;
   int  checks = 0;
   int  cyc    = 0;
   ev_t sb[$];

   piano_key_encoder #(.DEBOUNCE_CYCLES(DEB), .NUM_KEYS(NK)) dut (
      .clk         (clk),
      .rst         (rst),
      .keys        (keys),
      .note        (note),
      .note_on     (note_on),
      .note_change (note_change)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic expect_ev(input logic on, input logic [2:0] nt);
      ev_t e;
      e.on  = on;
      e.nt  = nt;
      e.cyc = cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: reset values while rst is high, scoreboard match on every pulse
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_note", note, 0);
         chk("rst_note_on", note_on, 0);
         chk("rst_note_change", note_change, 0);
      end else if (note_change) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_note_on", note_on, e.on);
            chk("ev_note", note, e.nt);
         end
      end
   end

   initial begin
      // Reset held with keys idle
      step(5);
      rst = 1'b0;
      step(10);
      chk("idle_note_on", note_on, 0);

      // Single key 2 press, then release
      keys = 8'h04; expect_ev(1'b1, 3'd2);
      step(15);
      chk("held2_note", note, 2);
      chk("held2_on", note_on, 1);
      keys = 8'h00; expect_ev(1'b0, 3'd2);
      step(15);
      chk("rel2_note", note, 2);
      chk("rel2_on", note_on, 0);

      // Glitch one cycle short of the debounce window
      keys = 8'h01;
      step(DEB - 1);
      keys = 8'h00;
      step(15);
      chk("glitch_on", note_on, 0);

      // Two keys held: lowest wins, then the higher takes over
      keys = 8'h30; expect_ev(1'b1, 3'd4);
      step(15);
      chk("pair_note", note, 4);
      keys = 8'h20; expect_ev(1'b1, 3'd5);
      step(15);
      chk("upper_note", note, 5);

      // Release of key 5 and press of key 0 complete in the same cycle
      keys = 8'h01; expect_ev(1'b1, 3'd0);
      step(15);
      chk("swap_note", note, 0);
      chk("swap_on", note_on, 1);

      // Key 5 playing, key 3 added and reset mid-count
      keys = 8'h20; expect_ev(1'b1, 3'd5);
      step(15);
      chk("pre_rst_note", note, 5);
      keys = 8'h28;
      step(4);
      rst = 1'b1;
      #1;
      chk("async_note", note, 0);
      chk("async_on", note_on, 0);
      chk("async_chg", note_change, 0);
      step(2);
      rst = 1'b0; expect_ev(1'b1, 3'd3);
      step(15);
      chk("post_rst_note", note, 3);
      chk("post_rst_on", note_on, 1);

      // Final release
      keys = 8'h00; expect_ev(1'b0, 3'd3);
      step(15);
      chk("final_on", note_on, 0);
      chk("pending_events", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout cyc=%0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
